// File: rtl/ex_mem_pkg.sv
// Shared constants and field-select helper for the EX/MEM pipeline register.
package ex_mem_pkg;

  localparam logic       RST_ENABLE   = 1'b0;
  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [4:0] NOP_REG_ADDR = 5'b00000;

  typedef enum logic [1:0] {
    SEL_LOAD   = 2'd0,
    SEL_HOLD   = 2'd1,
    SEL_BUBBLE = 2'd2,
    SEL_FLUSH  = 2'd3
  } field_sel_e;

  // stall[2] is EX, stall[3] is MEM; flush beats every stall combination.
  // MEM stalled with EX running cannot come from the controller and falls to load.
  function automatic field_sel_e stage_sel(input logic flush, input logic [4:0] stall);
    if (flush)                return SEL_FLUSH;
    if (stall[2] && !stall[3]) return SEL_BUBBLE;
    if (!stall[2])            return SEL_LOAD;
    return SEL_HOLD;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_field_reg.sv
// One group of EX/MEM fields: reset/clear to a per-group NOP value, load, or hold.
module pipe_field_reg
  import ex_mem_pkg::*;
#(
  parameter int           W       = 1,
  parameter logic [W-1:0] NOP_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   sel,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      q <= NOP_VAL;
    end else begin
      case (sel)
        SEL_LOAD:              q <= d;
        SEL_BUBBLE, SEL_FLUSH: q <= NOP_VAL;
        default:               q <= q;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with bubble/hold handling and the madd/msub carry path.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int REG_W   = 32,
  parameter int ADDR_W  = 5,
  parameter int ALUOP_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           stall,
  input  logic                 flush,
  input  logic [ADDR_W-1:0]    ex_wd,
  input  logic                 ex_wreg,
  input  logic [REG_W-1:0]     ex_wdata,
  input  logic                 ex_whilo,
  input  logic [REG_W-1:0]     ex_hi,
  input  logic [REG_W-1:0]     ex_lo,
  input  logic [ALUOP_W-1:0]   ex_aluop,
  input  logic [REG_W-1:0]     ex_mem_addr,
  input  logic [REG_W-1:0]     ex_reg2,
  input  logic                 ex_cp0_reg_we,
  input  logic [4:0]           ex_cp0_reg_waddr,
  input  logic [REG_W-1:0]     ex_cp0_reg_data,
  input  logic [31:0]          ex_excepttype,
  input  logic                 ex_is_in_delayslot,
  input  logic [REG_W-1:0]     ex_current_inst_address,
  input  logic [2*REG_W-1:0]   hilo_i,
  input  logic [1:0]           cnt_i,
  output logic [ADDR_W-1:0]    mem_wd,
  output logic                 mem_wreg,
  output logic [REG_W-1:0]     mem_wdata,
  output logic                 mem_whilo,
  output logic [REG_W-1:0]     mem_hi,
  output logic [REG_W-1:0]     mem_lo,
  output logic [ALUOP_W-1:0]   mem_aluop,
  output logic [REG_W-1:0]     mem_mem_addr,
  output logic [REG_W-1:0]     mem_reg2,
  output logic                 mem_cp0_reg_we,
  output logic [4:0]           mem_cp0_reg_waddr,
  output logic [REG_W-1:0]     mem_cp0_reg_data,
  output logic [31:0]          mem_excepttype,
  output logic                 mem_is_in_delayslot,
  output logic [REG_W-1:0]     mem_current_inst_address,
  output logic [2*REG_W-1:0]   hilo_o,
  output logic [1:0]           cnt_o
);

  localparam int WB_W  = ADDR_W + 1 + REG_W;
  localparam int HL_W  = 1 + 2*REG_W;
  localparam int LS_W  = ALUOP_W + 2*REG_W;
  localparam int CP0_W = 1 + 5 + REG_W;
  localparam int EXC_W = 32 + 1 + REG_W;

  field_sel_e sel;
  assign sel = stage_sel(flush, stall);

  // Only EX/MEM stall bits steer this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[4], stall[1:0]};

  pipe_field_reg #(.W(WB_W), .NOP_VAL({ADDR_W'(NOP_REG_ADDR), {(1+REG_W){1'b0}}})) u_wb (
    .clk(clk), .rst(rst), .sel(sel),
    .d({ex_wd, ex_wreg, ex_wdata}),
    .q({mem_wd, mem_wreg, mem_wdata})
  );

  pipe_field_reg #(.W(HL_W), .NOP_VAL('0)) u_hilo (
    .clk(clk), .rst(rst), .sel(sel),
    .d({ex_whilo, ex_hi, ex_lo}),
    .q({mem_whilo, mem_hi, mem_lo})
  );

  pipe_field_reg #(.W(LS_W), .NOP_VAL({ALUOP_W'(EXE_NOP_OP), {(2*REG_W){1'b0}}})) u_ls (
    .clk(clk), .rst(rst), .sel(sel),
    .d({ex_aluop, ex_mem_addr, ex_reg2}),
    .q({mem_aluop, mem_mem_addr, mem_reg2})
  );

  pipe_field_reg #(.W(CP0_W), .NOP_VAL('0)) u_cp0 (
    .clk(clk), .rst(rst), .sel(sel),
    .d({ex_cp0_reg_we, ex_cp0_reg_waddr, ex_cp0_reg_data}),
    .q({mem_cp0_reg_we, mem_cp0_reg_waddr, mem_cp0_reg_data})
  );

  pipe_field_reg #(.W(EXC_W), .NOP_VAL('0)) u_exc (
    .clk(clk), .rst(rst), .sel(sel),
    .d({ex_excepttype, ex_is_in_delayslot, ex_current_inst_address}),
    .q({mem_excepttype, mem_is_in_delayslot, mem_current_inst_address})
  );

  // The madd/msub carry survives a bubble (EX stalled, MEM moving) and is
  // cleared on advance, so EX sees it exactly in its second cycle.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      hilo_o <= '0;
      cnt_o  <= '0;
    end else begin
      case (sel)
        SEL_BUBBLE: begin
          hilo_o <= hilo_i;
          cnt_o  <= cnt_i;
        end
        SEL_HOLD: begin
          hilo_o <= hilo_o;
          cnt_o  <= cnt_o;
        end
        default: begin
          hilo_o <= '0;
          cnt_o  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem.sv
// Directed and random stimulus for ex_mem against a behavioural next-state model.
module tb_ex_mem;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  aluop;
    logic [31:0] maddr;
    logic [31:0] reg2;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_data;
    logic [31:0] exc;
    logic        dslot;
    logic [31:0] pc;
  } stage_t;

  logic        clk, rst, flush;
  logic [4:0]  stall;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  stage_t      drv;

  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_whilo, mem_cp0_reg_we, mem_is_in_delayslot;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic [7:0]  mem_aluop;
  logic [4:0]  mem_cp0_reg_waddr;
  logic [31:0] mem_cp0_reg_data, mem_excepttype, mem_current_inst_address;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  stage_t      exp_s;
  logic [63:0] exp_hilo;
  logic [1:0]  exp_cnt;
  int          n_chk = 0;
  int          n_fail = 0;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(drv.wd), .ex_wreg(drv.wreg), .ex_wdata(drv.wdata),
    .ex_whilo(drv.whilo), .ex_hi(drv.hi), .ex_lo(drv.lo),
    .ex_aluop(drv.aluop), .ex_mem_addr(drv.maddr), .ex_reg2(drv.reg2),
    .ex_cp0_reg_we(drv.cp0_we), .ex_cp0_reg_waddr(drv.cp0_waddr),
    .ex_cp0_reg_data(drv.cp0_data), .ex_excepttype(drv.exc),
    .ex_is_in_delayslot(drv.dslot), .ex_current_inst_address(drv.pc),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .mem_cp0_reg_we(mem_cp0_reg_we), .mem_cp0_reg_waddr(mem_cp0_reg_waddr),
    .mem_cp0_reg_data(mem_cp0_reg_data), .mem_excepttype(mem_excepttype),
    .mem_is_in_delayslot(mem_is_in_delayslot),
    .mem_current_inst_address(mem_current_inst_address),
    .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller protocol monitor: MEM must never stall while EX runs.
  always @(posedge clk)
    if (rst && stall[3] && !stall[2]) $error("illegal stall vector %b", stall);

  function automatic stage_t nop_stage();
    stage_t s = '0;
    s.wd    = 5'd0;
    s.aluop = 8'h00;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("mem_wd",        64'(mem_wd),                   64'(exp_s.wd));
    chk("mem_wreg",      64'(mem_wreg),                 64'(exp_s.wreg));
    chk("mem_wdata",     64'(mem_wdata),                64'(exp_s.wdata));
    chk("mem_whilo",     64'(mem_whilo),                64'(exp_s.whilo));
    chk("mem_hi",        64'(mem_hi),                   64'(exp_s.hi));
    chk("mem_lo",        64'(mem_lo),                   64'(exp_s.lo));
    chk("mem_aluop",     64'(mem_aluop),                64'(exp_s.aluop));
    chk("mem_mem_addr",  64'(mem_mem_addr),             64'(exp_s.maddr));
    chk("mem_reg2",      64'(mem_reg2),                 64'(exp_s.reg2));
    chk("mem_cp0_we",    64'(mem_cp0_reg_we),           64'(exp_s.cp0_we));
    chk("mem_cp0_waddr", 64'(mem_cp0_reg_waddr),        64'(exp_s.cp0_waddr));
    chk("mem_cp0_data",  64'(mem_cp0_reg_data),         64'(exp_s.cp0_data));
    chk("mem_exc",       64'(mem_excepttype),           64'(exp_s.exc));
    chk("mem_dslot",     64'(mem_is_in_delayslot),      64'(exp_s.dslot));
    chk("mem_pc",        64'(mem_current_inst_address), 64'(exp_s.pc));
    chk("hilo_o",        hilo_o,                        exp_hilo);
    chk("cnt_o",         64'(cnt_o),                    64'(exp_cnt));
  endtask

  // Next-state model straight from the stage rules, then compare just after the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst || flush) begin
      exp_s = nop_stage(); exp_hilo = '0; exp_cnt = '0;
    end else if (stall[2] && !stall[3]) begin
      exp_s = nop_stage(); exp_hilo = hilo_i; exp_cnt = cnt_i;
    end else if (!stall[2]) begin
      exp_s = drv; exp_hilo = '0; exp_cnt = '0;
    end
    #1;
    check_all();
  endtask

  task automatic rand_inputs();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    drv    = r[$bits(stage_t)-1:0];
    hilo_i = {$urandom, $urandom};
    cnt_i  = 2'($urandom_range(0, 3));
  endtask

  initial begin
    exp_s = nop_stage(); exp_hilo = '0; exp_cnt = '0;
    rst = 1'b0; flush = 1'b1; stall = 5'h1f;
    drv = '1; hilo_i = '1; cnt_i = '1;

    // Reset with every input high
    tick(); tick();
    chk("rst_aluop", 64'(mem_aluop), 64'h0);
    chk("rst_wreg",  64'(mem_wreg),  64'h0);
    chk("rst_hilo",  hilo_o,         64'h0);

    // Advance
    rst = 1'b1; flush = 1'b0; stall = 5'b00000;
    drv = '0; drv.wd = 5'd9; drv.wreg = 1'b1; drv.wdata = 32'h1234_5678;
    drv.maddr = 32'h8000_0010; drv.aluop = 8'h23;
    tick();
    chk("adv_wd",    64'(mem_wd),       64'd9);
    chk("adv_wdata", 64'(mem_wdata),    64'h1234_5678);
    chk("adv_addr",  64'(mem_mem_addr), 64'h8000_0010);

    // Bubble carries madd partial product, next advance clears it
    stall = 5'b00111; hilo_i = 64'h0000_0001_FFFF_FFFE; cnt_i = 2'd1;
    tick();
    chk("bub_wreg",  64'(mem_wreg),  64'h0);
    chk("bub_aluop", 64'(mem_aluop), 64'h0);
    chk("bub_hilo",  hilo_o,         64'h0000_0001_FFFF_FFFE);
    chk("bub_cnt",   64'(cnt_o),     64'd1);
    stall = 5'b00000;
    tick();
    chk("adv2_hilo", hilo_o,     64'h0);
    chk("adv2_cnt",  64'(cnt_o), 64'h0);

    // Hold for three cycles with changing inputs
    drv.wdata = 32'hDEAD_BEEF;
    tick();
    stall = 5'b01111;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      tick();
    end
    chk("hold_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);

    // Flush overrides hold with a live carry
    stall = 5'b00111; hilo_i = 64'hCAFE_0000_0000_BEEF; cnt_i = 2'd1;
    tick();
    stall = 5'b01111; rand_inputs();
    tick();
    chk("hold_hilo", hilo_o, 64'hCAFE_0000_0000_BEEF);
    flush = 1'b1;
    tick();
    chk("flush_hilo",  hilo_o,         64'h0);
    chk("flush_aluop", 64'(mem_aluop), 64'h0);
    flush = 1'b0;

    // Reset mid-madd, then normal advance
    stall = 5'b00111; hilo_i = 64'h1111_2222_3333_4444; cnt_i = 2'd1;
    tick();
    rst = 1'b0;
    tick();
    chk("rstmid_cnt",  64'(cnt_o), 64'h0);
    chk("rstmid_hilo", hilo_o,     64'h0);
    rst = 1'b1; stall = 5'b00000; rand_inputs();
    tick();

    // Random legal traffic
    for (int i = 0; i < 300; i++) begin
      int r;
      rand_inputs();
      r = int'($urandom_range(0, 9));
      stall[1:0] = 2'($urandom_range(0, 3));
      if (r < 5)      stall[4:2] = 3'b000;
      else if (r < 8) stall[4:2] = 3'b001;
      else            stall[4:2] = 3'b111;
      flush = ($urandom_range(0, 14) == 0);
      rst   = ($urandom_range(0, 24) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
